// File: rtl/ahblite_master_mux2_pkg.sv
// rtl/ahblite_master_mux2_pkg.sv - shared encodings for the two-master AHB-Lite mux
//
// Purpose: data-phase owner encoding, HTRANS constants, downstream source
// selector and small helpers used by the mux top and its testbench.
// Ports: none (package).
package ahblite_master_mux2_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  // Where the downstream address/control comes from this cycle.
  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_PEND0 = 3'd1,
    SRC_PEND1 = 3'd2,
    SRC_LIVE0 = 3'd3,
    SRC_LIVE1 = 3'd4
  } src_e;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY never do.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == NONSEQ) || (htrans == SEQ);
  endfunction

  function automatic owner_e src_owner(input src_e src);
    owner_e own;
    case (src)
      SRC_PEND0, SRC_LIVE0: own = OWN_M0;
      SRC_PEND1, SRC_LIVE1: own = OWN_M1;
      default:              own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/ahblite_req_hold.sv
// rtl/ahblite_req_hold.sv - one-deep pending address/control slot for one master
//
// Purpose: remembers a live request that could not be issued so it can be
// replayed downstream later.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   capture_i               load slot from haddr_i/hwrite_i/hsize_i, set pending
//   release_i               slot issued downstream, clear pending
//   haddr_i/hwrite_i/hsize_i  live address/control of the master
//   pend_o                  slot holds an unissued request
//   haddr_o/hwrite_o/hsize_o  captured address/control
module ahblite_req_hold (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        capture_i,
  input  logic        release_i,
  input  logic [31:0] haddr_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  output logic        pend_o,
  output logic [31:0] haddr_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o
);

  logic        pend_q,   pend_d;
  logic [31:0] haddr_q,  haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q,  hsize_d;

  // Capture and release are mutually exclusive in practice: a master with a
  // pending slot has HREADY_Mx low and so cannot present a live request.
  always_comb begin
    pend_d   = pend_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    if (capture_i) begin
      pend_d   = 1'b1;
      haddr_d  = haddr_i;
      hwrite_d = hwrite_i;
      hsize_d  = hsize_i;
    end else if (release_i) begin
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q   <= 1'b0;
      haddr_q  <= 32'h0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
    end else begin
      pend_q   <= pend_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
    end
  end

  assign pend_o   = pend_q;
  assign haddr_o  = haddr_q;
  assign hwrite_o = hwrite_q;
  assign hsize_o  = hsize_q;

endmodule

// File: rtl/ahblite_master_mux2.sv
// rtl/ahblite_master_mux2.sv - merges two AHB-Lite masters onto one downstream master port
//
// Purpose: zero-latency pass-through when uncontended; a losing or stalled
// request is parked in a per-master slot and replayed as NONSEQ.
// Parameter: LIVE_PRIO_M1 - a live M1 request beats a live M0 request.
// Ports:
//   HCLK, HRESETn                              clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA_M0/_M1     upstream master requests
//   HREADY_M0/_M1, HRDATA_M0/_M1               upstream ready / read data
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA            downstream master port
//   HREADY, HRDATA                             downstream ready / read data
module ahblite_master_mux2
  import ahblite_master_mux2_pkg::*;
#(
  parameter bit LIVE_PRIO_M1 = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR_M0,
  input  logic [1:0]  HTRANS_M0,
  input  logic        HWRITE_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic [31:0] HWDATA_M0,
  output logic        HREADY_M0,
  output logic [31:0] HRDATA_M0,
  input  logic [31:0] HADDR_M1,
  input  logic [1:0]  HTRANS_M1,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic        HREADY_M1,
  output logic [31:0] HRDATA_M1,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  owner_e owner_q, owner_d;
  owner_e lock_q,  lock_d;
  src_e   src;

  logic        pend0, pend1;
  logic [31:0] paddr0, paddr1;
  logic        pwrite0, pwrite1;
  logic [2:0]  psize0, psize1;
  logic        live0, live1;
  logic        cap0, cap1, rel0, rel1;

  // A master with a parked request sees HREADY low until the slot is issued;
  // otherwise it only waits on its own data phase.
  assign HREADY_M0 = ~pend0 & ((owner_q == OWN_M0) ? HREADY : 1'b1);
  assign HREADY_M1 = ~pend1 & ((owner_q == OWN_M1) ? HREADY : 1'b1);

  assign live0 = HRESETn & is_active(HTRANS_M0) & HREADY_M0;
  assign live1 = HRESETn & is_active(HTRANS_M1) & HREADY_M1;

  // lock_q names the slot that was shown downstream during a stall. Forcing it
  // again keeps address/control stable even if the other master got parked
  // (and would otherwise win on slot priority) in the meantime.
  always_comb begin
    src = SRC_NONE;
    if (!HRESETn) begin
      src = SRC_NONE;
    end else if (lock_q == OWN_M0 && pend0) begin
      src = SRC_PEND0;
    end else if (lock_q == OWN_M1 && pend1) begin
      src = SRC_PEND1;
    end else if (pend0) begin
      src = SRC_PEND0;
    end else if (pend1) begin
      src = SRC_PEND1;
    end else if (LIVE_PRIO_M1 && live1) begin
      src = SRC_LIVE1;
    end else if (live0) begin
      src = SRC_LIVE0;
    end else if (live1) begin
      src = SRC_LIVE1;
    end
  end

  always_comb begin
    HTRANS = NONSEQ;
    HADDR  = HADDR_M0;
    HWRITE = HWRITE_M0;
    HSIZE  = HSIZE_M0;
    case (src)
      SRC_PEND0: begin
        HADDR  = paddr0;
        HWRITE = pwrite0;
        HSIZE  = psize0;
      end
      SRC_PEND1: begin
        HADDR  = paddr1;
        HWRITE = pwrite1;
        HSIZE  = psize1;
      end
      SRC_LIVE0: begin
        HADDR  = HADDR_M0;
        HWRITE = HWRITE_M0;
        HSIZE  = HSIZE_M0;
      end
      SRC_LIVE1: begin
        HADDR  = HADDR_M1;
        HWRITE = HWRITE_M1;
        HSIZE  = HSIZE_M1;
      end
      default: HTRANS = IDLE;
    endcase
  end

  // A live request that does not complete its address phase this edge is
  // parked; a stalled live transfer is parked too and replayed from the slot.
  assign cap0 = live0 & ~((src == SRC_LIVE0) & HREADY);
  assign cap1 = live1 & ~((src == SRC_LIVE1) & HREADY);
  assign rel0 = (src == SRC_PEND0) & HREADY;
  assign rel1 = (src == SRC_PEND1) & HREADY;

  always_comb begin
    owner_d = owner_q;
    lock_d  = OWN_NONE;
    if (HREADY) begin
      owner_d = src_owner(src);
    end else begin
      lock_d  = src_owner(src);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q <= OWN_NONE;
      lock_q  <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
      lock_q  <= lock_d;
    end
  end

  assign HWDATA    = (owner_q == OWN_M1) ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA;
  assign HRDATA_M1 = HRDATA;

  ahblite_req_hold u_hold0 (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .capture_i (cap0),
    .release_i (rel0),
    .haddr_i   (HADDR_M0),
    .hwrite_i  (HWRITE_M0),
    .hsize_i   (HSIZE_M0),
    .pend_o    (pend0),
    .haddr_o   (paddr0),
    .hwrite_o  (pwrite0),
    .hsize_o   (psize0)
  );

  ahblite_req_hold u_hold1 (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .capture_i (cap1),
    .release_i (rel1),
    .haddr_i   (HADDR_M1),
    .hwrite_i  (HWRITE_M1),
    .hsize_i   (HSIZE_M1),
    .pend_o    (pend1),
    .haddr_o   (paddr1),
    .hwrite_o  (pwrite1),
    .hsize_o   (psize1)
  );

endmodule

// File: tb/tb_ahblite_master_mux2.sv
// tb/tb_ahblite_master_mux2.sv - self-checking bench for ahblite_master_mux2
module tb_ahblite_master_mux2;
  import ahblite_master_mux2_pkg::*;

  localparam logic [31:0] WD0 = 32'hA0A0_0000;
  localparam logic [31:0] WD1 = 32'hB1B1_0001;
  localparam logic [2:0]  SZ0 = 3'b010;
  localparam logic [2:0]  SZ1 = 3'b001;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR_M0, HADDR_M1, HRDATA;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HWRITE_M0, HWRITE_M1, HREADY;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic [31:0] HWDATA_M0, HWDATA_M1;

  logic        HREADY_M0, HREADY_M1;
  logic [31:0] HRDATA_M0, HRDATA_M1, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;

  logic        p_ready_m0, p_ready_m1, p_hwrite;
  logic [31:0] p_rdata_m0, p_rdata_m1, p_haddr, p_hwdata;
  logic [1:0]  p_htrans;
  logic [2:0]  p_hsize;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 HCLK = ~HCLK;

  ahblite_master_mux2 #(.LIVE_PRIO_M1(1'b0)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0), .HRDATA_M0(HRDATA_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1), .HRDATA_M1(HRDATA_M1),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  ahblite_master_mux2 #(.LIVE_PRIO_M1(1'b1)) u_dut_p1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(p_ready_m0), .HRDATA_M0(p_rdata_m0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(p_ready_m1), .HRDATA_M1(p_rdata_m1),
    .HADDR(p_haddr), .HTRANS(p_htrans), .HWRITE(p_hwrite), .HSIZE(p_hsize), .HWDATA(p_hwdata),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  typedef struct {
    logic [1:0]  t0;
    logic [31:0] a0;
    logic        w0;
    logic [1:0]  t1;
    logic [31:0] a1;
    logic        w1;
    logic        rdy;
    int          npush;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [1:0]  e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic        e_m1src;
    logic        e_rdy0;
    logic        e_rdy1;
    logic        e_wsel;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic [1:0] t0, input logic [31:0] a0, input logic w0,
    input logic [1:0] t1, input logic [31:0] a1, input logic w1,
    input logic rdy, input int npush, input logic [31:0] pa, input logic [31:0] pb,
    input logic [1:0] e_trans, input logic [31:0] e_addr, input logic e_write,
    input logic e_m1src, input logic e_rdy0, input logic e_rdy1, input logic e_wsel);
    vec_t v;
    v.t0 = t0; v.a0 = a0; v.w0 = w0; v.t1 = t1; v.a1 = a1; v.w1 = w1;
    v.rdy = rdy; v.npush = npush; v.pa = pa; v.pb = pb;
    v.e_trans = e_trans; v.e_addr = e_addr; v.e_write = e_write; v.e_m1src = e_m1src;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_wsel = e_wsel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic w0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic w1,
                       input logic rdy);
    HTRANS_M0 = t0; HADDR_M0 = a0; HWRITE_M0 = w0;
    HTRANS_M1 = t1; HADDR_M1 = a1; HWRITE_M1 = w1;
    HREADY = rdy;
  endtask

  // Every completed downstream address phase must match the next queued address.
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && HREADY === 1'b1 && HTRANS[1] === 1'b1) begin
      chk("issue htrans", {30'h0, HTRANS}, {30'h0, NONSEQ});
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue unexpected: addr %h with empty queue", HADDR);
      end else begin
        chk("issue order", HADDR, sb_q.pop_front());
      end
    end
  end

  initial begin
    // Row fields: t0 a0 w0 | t1 a1 w1 | HREADY | pushes | exp HTRANS HADDR HWRITE m1src rdy0 rdy1 wsel
    vecs[0]  = mk(NONSEQ, 32'h2000_0010, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 1, 32'h2000_0010, 32'h0,
                  NONSEQ, 32'h2000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(NONSEQ, 32'h4000_0000, 1'b1, NONSEQ, 32'h0000_0100, 1'b0, 1'b1, 2, 32'h4000_0000, 32'h0000_0100,
                  NONSEQ, 32'h4000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[3]  = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  NONSEQ, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[5]  = mk(IDLE, 32'h0, 1'b0, NONSEQ, 32'h0000_0300, 1'b0, 1'b1, 1, 32'h0000_0300, 32'h0,
                  NONSEQ, 32'h0000_0300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(NONSEQ, 32'h4000_0004, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 1, 32'h4000_0004, 32'h0,
                  NONSEQ, 32'h4000_0004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[7]  = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h0,
                  NONSEQ, 32'h4000_0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[8]  = vecs[7];
    vecs[9]  = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  NONSEQ, 32'h4000_0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[10] = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(IDLE, 32'h0, 1'b0, NONSEQ, 32'h0000_1000, 1'b0, 1'b1, 1, 32'h0000_1000, 32'h0,
                  NONSEQ, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[12] = mk(NONSEQ, 32'h0000_5000, 1'b1, SEQ, 32'h0000_1004, 1'b0, 1'b1, 2, 32'h0000_5000, 32'h0000_1004,
                  NONSEQ, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs[13] = mk(IDLE, 32'h0, 1'b0, SEQ, 32'h0000_1008, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  NONSEQ, 32'h0000_1004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(IDLE, 32'h0, 1'b0, SEQ, 32'h0000_1008, 1'b0, 1'b1, 1, 32'h0000_1008, 32'h0,
                  NONSEQ, 32'h0000_1008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[15] = mk(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1, 0, 32'h0, 32'h0,
                  IDLE, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    HWDATA_M0 = WD0; HWDATA_M1 = WD1; HSIZE_M0 = SZ0; HSIZE_M1 = SZ1;
    HRDATA = 32'h0;
    HRESETn = 1'b0;
    // Live requests during reset must not reach the downstream port.
    drive(NONSEQ, 32'h0000_0AA0, 1'b0, NONSEQ, 32'h0000_0BB0, 1'b0, 1'b1);
    @(negedge HCLK);
    chk("reset htrans", {30'h0, HTRANS}, {30'h0, IDLE});
    chk("reset hready_m0", {31'h0, HREADY_M0}, 32'h1);
    chk("reset hready_m1", {31'h0, HREADY_M1}, 32'h1);
    chk("reset p1 htrans", {30'h0, p_htrans}, {30'h0, IDLE});
    drive(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge HCLK); #1;
      drive(vecs[i].t0, vecs[i].a0, vecs[i].w0, vecs[i].t1, vecs[i].a1, vecs[i].w1, vecs[i].rdy);
      HRDATA = $urandom;
      if (vecs[i].npush > 0) sb_q.push_back(vecs[i].pa);
      if (vecs[i].npush > 1) sb_q.push_back(vecs[i].pb);
      @(negedge HCLK);
      chk($sformatf("r%0d htrans", i), {30'h0, HTRANS}, {30'h0, vecs[i].e_trans});
      chk($sformatf("r%0d haddr", i), HADDR, vecs[i].e_addr);
      chk($sformatf("r%0d hwrite", i), {31'h0, HWRITE}, {31'h0, vecs[i].e_write});
      chk($sformatf("r%0d hsize", i), {29'h0, HSIZE}, {29'h0, (vecs[i].e_m1src ? SZ1 : SZ0)});
      chk($sformatf("r%0d hready_m0", i), {31'h0, HREADY_M0}, {31'h0, vecs[i].e_rdy0});
      chk($sformatf("r%0d hready_m1", i), {31'h0, HREADY_M1}, {31'h0, vecs[i].e_rdy1});
      chk($sformatf("r%0d hwdata", i), HWDATA, vecs[i].e_wsel ? WD1 : WD0);
      chk($sformatf("r%0d hrdata_m0", i), HRDATA_M0, HRDATA);
      chk($sformatf("r%0d hrdata_m1", i), HRDATA_M1, HRDATA);
    end

    // Live-priority M1 instance: M1 first, M0 parked; default instance does the opposite.
    @(posedge HCLK); #1;
    drive(NONSEQ, 32'h0000_0600, 1'b0, NONSEQ, 32'h0000_0700, 1'b0, 1'b1);
    sb_q.push_back(32'h0000_0600);
    sb_q.push_back(32'h0000_0700);
    @(negedge HCLK);
    chk("prio1 first haddr", p_haddr, 32'h0000_0700);
    chk("prio1 first htrans", {30'h0, p_htrans}, {30'h0, NONSEQ});
    chk("prio0 first haddr", HADDR, 32'h0000_0600);
    @(posedge HCLK); #1;
    drive(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1);
    @(negedge HCLK);
    chk("prio1 second haddr", p_haddr, 32'h0000_0600);
    chk("prio1 hready_m0 parked", {31'h0, p_ready_m0}, 32'h0);
    chk("prio1 hready_m1", {31'h0, p_ready_m1}, 32'h1);
    chk("prio0 second haddr", HADDR, 32'h0000_0700);
    @(posedge HCLK); #1;
    drive(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1);

    // Reset while M1 is parked and the downstream is stalled.
    @(posedge HCLK); #1;
    drive(NONSEQ, 32'h0000_0800, 1'b0, NONSEQ, 32'h0000_0900, 1'b0, 1'b1);
    sb_q.push_back(32'h0000_0800);
    @(negedge HCLK);
    chk("rst seq hready_m1 before park", {31'h0, HREADY_M1}, 32'h1);
    @(posedge HCLK); #1;
    drive(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    chk("rst seq stalled htrans", {30'h0, HTRANS}, {30'h0, NONSEQ});
    chk("rst seq stalled haddr", HADDR, 32'h0000_0900);
    chk("rst seq hready_m1 parked", {31'h0, HREADY_M1}, 32'h0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("async rst htrans", {30'h0, HTRANS}, {30'h0, IDLE});
    chk("async rst hready_m0", {31'h0, HREADY_M0}, 32'h1);
    chk("async rst hready_m1", {31'h0, HREADY_M1}, 32'h1);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("post rst htrans", {30'h0, HTRANS}, {30'h0, IDLE});
    chk("post rst hready_m1", {31'h0, HREADY_M1}, 32'h1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("post rst idle htrans", {30'h0, HTRANS}, {30'h0, IDLE});
    chk("scoreboard drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahblite_master_mux2.md
AHBLITE_MASTER_MUX2 -- requirements
Module: ahblite_master_mux2

Interface
REQ-001 SHALL have parameter LIVE_PRIO_M1, default 0: when 1, a live M1 request beats a live M0 request; pending-request order is unaffected.
REQ-002 SHALL have port HCLK, input, 1: sole clock; all state on rising edge.
REQ-003 SHALL have port HRESETn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports HADDR_M0 / HADDR_M1, input, 32 each: upstream master address.
REQ-005 SHALL have ports HTRANS_M0 / HTRANS_M1, input, 2 each: upstream transfer type.
REQ-006 SHALL have ports HWRITE_M0 / HWRITE_M1, input, 1 each: upstream write flag.
REQ-007 SHALL have ports HSIZE_M0 / HSIZE_M1, input, 3 each: upstream transfer size.
REQ-008 SHALL have ports HWDATA_M0 / HWDATA_M1, input, 32 each: upstream write data.
REQ-009 SHALL have ports HREADY_M0 / HREADY_M1, output, 1 each: per-master ready.
REQ-010 SHALL have ports HRDATA_M0 / HRDATA_M1, output, 32 each: per-master read data.
REQ-011 SHALL have ports HADDR, HTRANS, HWRITE, HSIZE, HWDATA, output, 32/2/1/3/32: single downstream master port into the AHB-Lite system.
REQ-012 SHALL have ports HREADY and HRDATA, input, 1/32: downstream ready and read data.

Function
REQ-013 A live request SHALL be HTRANS_Mx[1]=1 with HREADY_Mx=1; BUSY and IDLE are never captured or forwarded.
REQ-014 Per master, the block SHALL hold one pending slot (pend_x flag plus HADDR/HWRITE/HSIZE).
REQ-015 The downstream source SHALL be chosen in order pend0, pend1, live winner (M0 unless LIVE_PRIO_M1), other live; with none, HTRANS=IDLE and address/control = M0 inputs.
REQ-016 Any selected transfer SHALL be driven downstream with HTRANS=NONSEQ (2'b10), whatever the source type.
REQ-017 A live request not issued this cycle (lost arbitration, or HREADY=0) SHALL set pend_x and capture its address/control on that edge.
REQ-018 pend_x SHALL clear on the edge where its slot is selected and HREADY=1.
REQ-019 data_owner (NONE/M0/M1) SHALL update only when HREADY=1: to the selected source if a transfer is issued, else NONE.
REQ-020 HWDATA SHALL be HWDATA_M1 when data_owner=M1, else HWDATA_M0.
REQ-021 HRDATA_M0 and HRDATA_M1 SHALL both equal HRDATA combinationally.
REQ-022 HREADY_Mx SHALL be ~pend_x AND (data_owner==x ? HREADY : 1).
REQ-023 Downstream address/control SHALL remain stable while HREADY=0: a live source shown during a stall is captured (REQ-017) and re-driven from its slot next cycle.
REQ-024 With no contention, latency SHALL be zero: the live request is issued in its own address cycle.
REQ-025 A granted pending request SHALL reach its data phase one cycle after issue; the master's next address is accepted only in that data-phase cycle.

Reset
REQ-026 While HRESETn=0: pend0=pend1=0, data_owner=NONE, HTRANS=IDLE, HREADY_M0=HREADY_M1=1. Any transfer in flight SHALL be abandoned; no pending state survives.

Structure
REQ-027 A shared package SHALL hold owner encodings (OWN_NONE, OWN_M0, OWN_M1) and HTRANS constants (IDLE, BUSY, NONSEQ, SEQ).
REQ-028 The pending slot SHALL be sub-module ahblite_req_hold, instantiated once per master.
REQ-029 The arbiter select and data_owner register SHALL live in the top module.

Verification
REQ-030 M0 read 0x2000_0010 alone, HREADY=1 -> HADDR=0x2000_0010 same cycle; HRDATA_M0 = slave data next cycle; HREADY_M1 stays 1.
REQ-031 M0 write 0x4000_0000 and M1 read 0x0000_0100 in the same cycle -> M0 issued; pend1=1; HREADY_M1=0 for one cycle; M1 issued the next cycle; HWDATA follows the data owner.
REQ-032 M1 data phase with HREADY=0 for 3 cycles while M0 requests 0x4000_0004 -> pend0 set; HADDR constant all 3 cycles; M0 issued on the first HREADY=1 cycle.
REQ-033 M1 SEQ burst interrupted by M0 -> every downstream transfer shows HTRANS=2'b10, addresses in arrival order.
REQ-034 LIVE_PRIO_M1=1 with both masters live -> M1 issued first, M0 pended.
REQ-035 HRESETn low while pend1=1 and HREADY=0 -> pend cleared, HTRANS=IDLE, both HREADY_Mx=1 immediately.
